// File: rtl/br_rx_buffer.sv
// br_rx_buffer: broadcast receive FIFO feeding the DMNI kernel-service MMRs.
// Packets from the broadcast router are queued in a circular buffer. The head
// packet is exposed through DMNI_BR_KSVC (0x40) and DMNI_BR_PAYLOAD (0x44).
// Reading the payload register pops the head. Writing bit 0 of the KSVC
// register flushes the queue.
module br_rx_buffer #(
    parameter int  BR_BUFFER_SIZE = 8,
    localparam int PTR_W          = $clog2(BR_BUFFER_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             br_req_i,
    output logic             br_ack_o,
    input  logic [35:0]      br_payload_i,
    input  logic             cfg_en_i,
    input  logic             cfg_we_i,
    input  logic [7:0]       cfg_addr_i,
    input  logic [31:0]      cfg_data_i,
    output logic [31:0]      cfg_data_o,
    output logic             pending_o,
    output logic             full_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [7:0]       ADDR_BR_KSVC    = 8'h40;
    localparam logic [7:0]       ADDR_BR_PAYLOAD = 8'h44;
    localparam logic [PTR_W:0]   DEPTH           = BR_BUFFER_SIZE[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE         = 1;
    localparam logic [PTR_W-1:0] PTR_ONE         = 1;

    logic [35:0]      mem [BR_BUFFER_SIZE];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic             ready_q;

    logic [35:0]      head_entry;
    logic             not_empty;
    logic             push;
    logic             cfg_read;
    logic             pop;
    logic             flush;
    logic             unused_cfg_bits;

    // Only bit 0 of the write data carries meaning (the flush request).
    assign unused_cfg_bits = ^cfg_data_i[31:1];

    assign head_entry = mem[head_q];
    assign not_empty  = (count_q != '0);
    assign pending_o  = not_empty;
    assign full_o     = (count_q == DEPTH);
    assign count_o    = count_q;

    // ready_q keeps ack low through reset and the reset-release edge.
    assign br_ack_o   = ready_q && !full_o;
    assign push       = br_req_i && br_ack_o;
    assign cfg_read   = cfg_en_i && !cfg_we_i;
    assign pop        = cfg_read && (cfg_addr_i == ADDR_BR_PAYLOAD) && not_empty;
    assign flush      = cfg_en_i && cfg_we_i && (cfg_addr_i == ADDR_BR_KSVC) && cfg_data_i[0];

    // Packet storage: written at the tail on every accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[tail_q] <= br_payload_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush drops everything except a push in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (flush) begin
                head_q  <= tail_q;
                count_q <= push ? CNT_ONE : '0;
            end else begin
                if (pop) begin
                    head_q <= head_q + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Registered read data; empty reads and unknown addresses return zero, otherwise the value holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_data_o <= '0;
        end else if (cfg_read) begin
            if (cfg_addr_i == ADDR_BR_KSVC && not_empty) begin
                cfg_data_o <= {28'b0, head_entry[3:0]};
            end else if (cfg_addr_i == ADDR_BR_PAYLOAD && not_empty) begin
                cfg_data_o <= {head_entry[19:4], head_entry[35:20]};
            end else begin
                cfg_data_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_br_rx_buffer.sv
// tb_br_rx_buffer: directed scoreboard bench for br_rx_buffer.
// Every MMR read queues its hand-computed expected value. A monitor compares
// cfg_data_o one cycle after each read. Status outputs are checked directly.
module tb_br_rx_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        br_req_i;
    logic        br_ack_o;
    logic [35:0] br_payload_i;
    logic        cfg_en_i;
    logic        cfg_we_i;
    logic [7:0]  cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic [31:0] cfg_data_o;
    logic        pending_o;
    logic        full_o;
    logic [3:0]  count_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_seen = 1'b0;

    br_rx_buffer #(.BR_BUFFER_SIZE(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .br_req_i     (br_req_i),
        .br_ack_o     (br_ack_o),
        .br_payload_i (br_payload_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_data_o   (cfg_data_o),
        .pending_o    (pending_o),
        .full_o       (full_o),
        .count_o      (count_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Note which edges carried an MMR read so the monitor knows when data is due.
    always @(posedge clk_i) begin
        rd_seen <= cfg_en_i && !cfg_we_i && rst_ni;
    end

    // Monitor: compare the read data against the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rd_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read: got %h, no expected value queued", cfg_data_o);
            end else begin
                logic [31:0] exp_val;
                string       exp_name;
                exp_val  = exp_q.pop_front();
                exp_name = name_q.pop_front();
                if (cfg_data_o !== exp_val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h, expected %h", exp_name, cfg_data_o, exp_val);
                end
            end
        end
    end

    function automatic logic [35:0] mk(input logic [15:0] pl, input logic [15:0] seq, input logic [3:0] k);
        return {pl, seq, k};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus from a negedge, queueing the read expectation if any.
    task automatic applyStimulus(input logic req, input logic [35:0] pkt,
                                 input logic en, input logic we, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_rd, input string name);
        br_req_i     = req;
        br_payload_i = pkt;
        cfg_en_i     = en;
        cfg_we_i     = we;
        cfg_addr_i   = addr;
        cfg_data_i   = data;
        if (en && !we) begin
            exp_q.push_back(exp_rd);
            name_q.push_back(name);
        end
        @(negedge clk_i);
        br_req_i   = 1'b0;
        cfg_en_i   = 1'b0;
        cfg_we_i   = 1'b0;
        cfg_addr_i = 8'h00;
        cfg_data_i = 32'h0;
    endtask

    task automatic pushPkt(input logic [35:0] pkt);
        applyStimulus(1'b1, pkt, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, "");
    endtask

    task automatic readAddr(input logic [7:0] addr, input logic [31:0] exp_rd, input string name);
        applyStimulus(1'b0, 36'h0, 1'b1, 1'b0, addr, 32'h0, exp_rd, name);
    endtask

    // Directed test sequence.
    initial begin
        rst_ni       = 1'b0;
        br_req_i     = 1'b0;
        br_payload_i = 36'h0;
        cfg_en_i     = 1'b0;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = 8'h00;
        cfg_data_i   = 32'h0;

        // Reset state and release.
        repeat (3) @(negedge clk_i);
        checkOutput("reset_ack", 32'(br_ack_o), 32'h0);
        checkOutput("reset_count", 32'(count_o), 32'h0);
        rst_ni = 1'b1;
        #1;
        checkOutput("release_ack_before_edge", 32'(br_ack_o), 32'h0);
        @(negedge clk_i);
        checkOutput("release_ack", 32'(br_ack_o), 32'h1);
        checkOutput("release_pending", 32'(pending_o), 32'h0);
        checkOutput("release_full", 32'(full_o), 32'h0);
        checkOutput("release_data", cfg_data_o, 32'h0);
        readAddr(8'h44, 32'h0, "empty_payload_read");
        checkOutput("empty_read_count", 32'(count_o), 32'h0);
        readAddr(8'h40, 32'h0, "empty_ksvc_read");

        // Single packet round trip.
        pushPkt(mk(16'hBEEF, 16'h0102, 4'h3));
        checkOutput("single_pending", 32'(pending_o), 32'h1);
        checkOutput("single_count", 32'(count_o), 32'h1);
        readAddr(8'h40, 32'h3, "single_ksvc");
        checkOutput("ksvc_no_pop", 32'(count_o), 32'h1);
        readAddr(8'h44, 32'h0102BEEF, "single_payload");
        checkOutput("single_pending_after", 32'(pending_o), 32'h0);

        // Fill to full, hold a ninth request, pop once, drain in order.
        for (int i = 0; i < 8; i++) begin
            pushPkt(mk(16'h0100 + 16'(i), 16'h0A00 + 16'(i), 4'(i)));
        end
        checkOutput("full_flag", 32'(full_o), 32'h1);
        checkOutput("full_ack", 32'(br_ack_o), 32'h0);
        checkOutput("full_count", 32'(count_o), 32'h8);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, mk(16'h0108, 16'h0A08, 4'h8), 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, "");
            checkOutput("ninth_blocked", 32'(count_o), 32'h8);
        end
        applyStimulus(1'b1, mk(16'h0108, 16'h0A08, 4'h8), 1'b1, 1'b0, 8'h44, 32'h0,
                      32'h0A000100, "full_pop_first");
        checkOutput("pop_while_full_count", 32'(count_o), 32'h7);
        checkOutput("ack_after_pop", 32'(br_ack_o), 32'h1);
        applyStimulus(1'b1, mk(16'h0108, 16'h0A08, 4'h8), 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, "");
        checkOutput("ninth_accepted", 32'(count_o), 32'h8);
        readAddr(8'h40, 32'h1, "drain_head_ksvc");
        for (int i = 1; i <= 8; i++) begin
            readAddr(8'h44, {16'h0A00 + 16'(i), 16'h0100 + 16'(i)}, "drain_order");
        end
        checkOutput("drain_count", 32'(count_o), 32'h0);
        checkOutput("drain_full", 32'(full_o), 32'h0);

        // Simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) begin
            pushPkt(mk(16'h0200 + 16'(i), 16'h0B00 + 16'(i), 4'hC));
        end
        checkOutput("count_three", 32'(count_o), 32'h3);
        applyStimulus(1'b1, mk(16'h0203, 16'h0B03, 4'hC), 1'b1, 1'b0, 8'h44, 32'h0,
                      32'h0B000200, "push_pop_oldest");
        checkOutput("push_pop_count", 32'(count_o), 32'h3);
        for (int i = 1; i <= 3; i++) begin
            readAddr(8'h44, {16'h0B00 + 16'(i), 16'h0200 + 16'(i)}, "push_pop_drain");
        end

        // Twenty push/pop pairs wrap both pointers.
        pushPkt(mk(16'h1000, 16'h2000, 4'h0));
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1'b1, mk(16'h1000 + 16'(i), 16'h2000 + 16'(i), 4'(i)), 1'b1, 1'b0, 8'h44, 32'h0,
                          {16'h2000 + 16'(i - 1), 16'h1000 + 16'(i - 1)}, "wrap_pop");
            checkOutput("wrap_count", 32'(count_o), 32'h1);
        end
        readAddr(8'h44, 32'h20131013, "wrap_last");
        checkOutput("wrap_empty", 32'(count_o), 32'h0);

        // Ignored writes, unknown address, held data, then flush with simultaneous push.
        for (int i = 0; i < 5; i++) begin
            pushPkt(mk(16'h3000 + 16'(i), 16'h4000 + 16'(i), 4'h5));
        end
        applyStimulus(1'b0, 36'h0, 1'b1, 1'b1, 8'h40, 32'h0, 32'h0, "");
        checkOutput("write_zero_ignored", 32'(count_o), 32'h5);
        applyStimulus(1'b0, 36'h0, 1'b1, 1'b1, 8'h44, 32'h1, 32'h0, "");
        checkOutput("write_payload_ignored", 32'(count_o), 32'h5);
        readAddr(8'h40, 32'h5, "queued_ksvc");
        readAddr(8'h48, 32'h0, "unknown_addr");
        readAddr(8'h40, 32'h5, "queued_ksvc_again");
        @(negedge clk_i);
        checkOutput("data_held", cfg_data_o, 32'h5);
        checkOutput("before_flush_count", 32'(count_o), 32'h5);
        applyStimulus(1'b1, mk(16'hCAFE, 16'h0606, 4'h9), 1'b1, 1'b1, 8'h40, 32'h1, 32'h0, "");
        checkOutput("flush_count", 32'(count_o), 32'h1);
        readAddr(8'h40, 32'h9, "flush_head_ksvc");
        readAddr(8'h44, 32'h0606CAFE, "flush_head_payload");
        checkOutput("flush_drained", 32'(count_o), 32'h0);

        // Asynchronous reset mid-stream, with a push held across release.
        for (int i = 0; i < 3; i++) begin
            pushPkt(mk(16'h5000 + 16'(i), 16'h6000 + 16'(i), 4'h7));
        end
        readAddr(8'h44, 32'h60005000, "pre_reset_pop");
        checkOutput("pre_reset_count", 32'(count_o), 32'h2);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async_reset_count", 32'(count_o), 32'h0);
        checkOutput("async_reset_pending", 32'(pending_o), 32'h0);
        checkOutput("async_reset_ack", 32'(br_ack_o), 32'h0);
        checkOutput("async_reset_data", cfg_data_o, 32'h0);
        @(negedge clk_i);
        br_req_i     = 1'b1;
        br_payload_i = mk(16'h7777, 16'h8888, 4'h1);
        rst_ni       = 1'b1;
        @(negedge clk_i);
        checkOutput("release_edge_push_dropped", 32'(count_o), 32'h0);
        checkOutput("release_edge_ack", 32'(br_ack_o), 32'h1);
        @(negedge clk_i);
        br_req_i = 1'b0;
        checkOutput("post_release_push", 32'(count_o), 32'h1);
        readAddr(8'h44, 32'h88887777, "post_release_payload");

        repeat (2) @(negedge clk_i);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
